// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: merges two buffered write-back requesters onto one register-file write port.
// Define REGFILE_WB_ARBITER_RR_EN for round-robin conflict arbitration; otherwise A wins conflicts.
module regfile_wb_arbiter (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        ValidA,
  output logic        ReadyA,
  input  logic [4:0]  AddrA,
  input  logic [31:0] DataA,
  input  logic        ValidB,
  output logic        ReadyB,
  input  logic [4:0]  AddrB,
  input  logic [31:0] DataB,
  output logic [4:0]  WriteRegister,
  output logic [31:0] WriteData,
  output logic        RegWrite,
  output logic        Busy,
  output logic [7:0]  DropCount
);

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 8;

  logic          full_a, full_b;
  logic          age_a, age_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] data_a, data_b;

  logic          xfer_a, xfer_b;
  logic          drain_a, drain_b;
  logic          conflict_pick_a;
  logic [AW-1:0] drain_addr;
  logic [DW-1:0] drain_data;

  assign ReadyA = !full_a;
  assign ReadyB = !full_b;
  assign Busy   = full_a || full_b;
  assign xfer_a = ValidA && !full_a;
  assign xfer_b = ValidB && !full_b;

`ifdef REGFILE_WB_ARBITER_RR_EN
  typedef enum logic {LAST_A, LAST_B} ptr_t;
  ptr_t ptr, ptr_next;

  // Pointer remembers which requester was drained most recently.
  always_ff @(posedge Clk) begin
    if (Reset) ptr <= LAST_B;
    else       ptr <= ptr_next;
  end

  always_comb begin
    ptr_next = ptr;
    if (drain_a)      ptr_next = LAST_A;
    else if (drain_b) ptr_next = LAST_B;
  end

  assign conflict_pick_a = (ptr == LAST_B);
`else
  assign conflict_pick_a = 1'b1;
`endif

  // Drain selection; same nonzero address keeps program order via the age bits.
  always_comb begin
    drain_a = 1'b0;
    drain_b = 1'b0;
    if (full_a && full_b) begin
      if ((addr_a == addr_b) && (addr_a != AW'(0))) drain_a = age_a || !age_b;
      else                                            drain_a = conflict_pick_a;
      drain_b = !drain_a;
    end else begin
      drain_a = full_a;
      drain_b = full_b;
    end
  end

  always_comb begin
    drain_addr = addr_b;
    drain_data = data_b;
    if (drain_a) begin
      drain_addr = addr_a;
      drain_data = data_a;
    end
  end

  // Requester buffers; an entry is older unless the other buffer keeps an entry across this edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      full_a <= 1'b0;
      full_b <= 1'b0;
      age_a  <= 1'b0;
      age_b  <= 1'b0;
      addr_a <= '0;
      addr_b <= '0;
      data_a <= '0;
      data_b <= '0;
    end else begin
      if (xfer_a) begin
        full_a <= 1'b1;
        addr_a <= AddrA;
        data_a <= DataA;
        age_a  <= !(full_b && !drain_b);
      end else begin
        if (drain_a) full_a <= 1'b0;
        if (xfer_b)  age_a  <= 1'b1;
      end
      if (xfer_b) begin
        full_b <= 1'b1;
        addr_b <= AddrB;
        data_b <= DataB;
        age_b  <= !(full_a && !drain_a) && !xfer_a;
      end else begin
        if (drain_b) full_b <= 1'b0;
        if (xfer_a)  age_b  <= 1'b1;
      end
    end
  end

  // Write-port registers; register 0 writes are consumed and counted but never enabled.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      WriteRegister <= '0;
      WriteData     <= '0;
      RegWrite      <= 1'b0;
      DropCount     <= '0;
    end else begin
      RegWrite <= 1'b0;
      if (drain_a || drain_b) begin
        WriteRegister <= drain_addr;
        WriteData     <= drain_data;
        RegWrite      <= (drain_addr != AW'(0));
        if ((drain_addr == AW'(0)) && (DropCount != {CW{1'b1}}))
          DropCount <= DropCount + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus randomized traffic vs a transaction model.
// Define REGFILE_WB_ARBITER_RR_EN to check the round-robin build.
module tb_regfile_wb_arbiter;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        ValidA = 1'b0, ValidB = 1'b0;
  logic        ReadyA, ReadyB;
  logic [4:0]  AddrA = '0, AddrB = '0;
  logic [31:0] DataA = '0, DataB = '0;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic        RegWrite, Busy;
  logic [7:0]  DropCount;

  regfile_wb_arbiter dut (
    .Clk(Clk), .Reset(Reset),
    .ValidA(ValidA), .ReadyA(ReadyA), .AddrA(AddrA), .DataA(DataA),
    .ValidB(ValidB), .ReadyB(ReadyB), .AddrB(AddrB), .DataB(DataB),
    .WriteRegister(WriteRegister), .WriteData(WriteData), .RegWrite(RegWrite),
    .Busy(Busy), .DropCount(DropCount)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: pending entries carry their capture time; ties go to A.
  bit          m_on = 1'b0;
  bit          m_full [2];
  logic [4:0]  m_addr [2];
  logic [31:0] m_data [2];
  longint      m_ts   [2];
  bit          m_rw = 1'b0;
  logic [4:0]  m_wr = '0;
  logic [31:0] m_wd = '0;
  int          m_drop = 0;
  longint      m_cycle = 0;
  logic [31:0] m_rf [32];
`ifdef REGFILE_WB_ARBITER_RR_EN
  int          m_last = 1;
`endif

  task automatic model_step();
    bit          v [2];
    bit          rdy [2];
    logic [4:0]  a [2];
    logic [31:0] d [2];
    int          pick;
    int          conflict_pick;
    v[0] = ValidA; a[0] = AddrA; d[0] = DataA;
    v[1] = ValidB; a[1] = AddrB; d[1] = DataB;
    m_cycle++;
    if (Reset) begin
      m_on = 1'b1;
      m_full[0] = 1'b0; m_full[1] = 1'b0;
      m_rw = 1'b0; m_wr = '0; m_wd = '0; m_drop = 0;
`ifdef REGFILE_WB_ARBITER_RR_EN
      m_last = 1;
`endif
    end else if (m_on) begin
      rdy[0] = !m_full[0];
      rdy[1] = !m_full[1];
`ifdef REGFILE_WB_ARBITER_RR_EN
      conflict_pick = 1 - m_last;
`else
      conflict_pick = 0;
`endif
      pick = -1;
      if (m_full[0] && m_full[1]) begin
        if (m_addr[0] == m_addr[1] && m_addr[0] != 5'd0)
          pick = (m_ts[0] <= m_ts[1]) ? 0 : 1;
        else
          pick = conflict_pick;
      end else if (m_full[0]) pick = 0;
      else if (m_full[1]) pick = 1;
      m_rw = 1'b0;
      if (pick >= 0) begin
        m_wr = m_addr[pick];
        m_wd = m_data[pick];
        m_full[pick] = 1'b0;
`ifdef REGFILE_WB_ARBITER_RR_EN
        m_last = pick;
`endif
        if (m_wr == 5'd0) begin
          if (m_drop < 255) m_drop++;
        end else begin
          m_rw = 1'b1;
          m_rf[m_wr] = m_wd;
        end
      end
      for (int i = 0; i < 2; i++) begin
        if (v[i] && rdy[i]) begin
          m_full[i] = 1'b1; m_addr[i] = a[i]; m_data[i] = d[i]; m_ts[i] = m_cycle;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge Clk);
    model_step();
  end

  // Write-port sink: bench-side register file and a log of committed writes.
  logic [31:0] rf_dut [32];
  logic [4:0]  alog [$];
  logic [31:0] dlog [$];
  int          rw_cnt = 0;

  initial forever begin
    @(negedge Clk);
    if (m_on) begin
      chk("ReadyA", 32'(ReadyA), 32'(!m_full[0]));
      chk("ReadyB", 32'(ReadyB), 32'(!m_full[1]));
      chk("Busy", 32'(Busy), 32'(m_full[0] || m_full[1]));
      chk("RegWrite", 32'(RegWrite), 32'(m_rw));
      chk("WriteRegister", 32'(WriteRegister), 32'(m_wr));
      chk("WriteData", WriteData, m_wd);
      chk("DropCount", 32'(DropCount), 32'(m_drop));
    end
    if (RegWrite === 1'b1) begin
      rf_dut[WriteRegister] = WriteData;
      alog.push_back(WriteRegister);
      dlog.push_back(WriteData);
      rw_cnt++;
    end
  end

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    ValidA = 1'b0;
    ValidB = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    Reset = 1'b1;
    cyc();
    Reset = 1'b0;
  endtask

  task automatic set_a(input logic [4:0] a, input logic [31:0] d);
    ValidA = 1'b1; AddrA = a; DataA = d;
  endtask

  task automatic set_b(input logic [4:0] a, input logic [31:0] d);
    ValidB = 1'b1; AddrB = a; DataB = d;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_ReadyA"}, 32'(ReadyA), 32'd1);
    chk({tag, "_ReadyB"}, 32'(ReadyB), 32'd1);
    chk({tag, "_RegWrite"}, 32'(RegWrite), 32'd0);
    chk({tag, "_WriteRegister"}, 32'(WriteRegister), 32'd0);
    chk({tag, "_WriteData"}, WriteData, 32'd0);
    chk({tag, "_Busy"}, 32'(Busy), 32'd0);
    chk({tag, "_DropCount"}, 32'(DropCount), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    int n;
    int iter;
    int rw_before;

    // Power-on reset
    cyc(); cyc();
    Reset = 1'b0;
    @(negedge Clk);
    chk_reset_values("por");

    // Single write: result on the port two edges after the transfer
    set_a(5'd5, 32'h1234_5678);
    cyc();
    idle();
    @(negedge Clk);
    chk("single_ReadyA_busy", 32'(ReadyA), 32'd0);
    chk("single_Busy_pending", 32'(Busy), 32'd1);
    chk("single_no_early_write", 32'(RegWrite), 32'd0);
    cyc();
    @(negedge Clk);
    chk("single_RegWrite", 32'(RegWrite), 32'd1);
    chk("single_WriteRegister", 32'(WriteRegister), 32'd5);
    chk("single_WriteData", WriteData, 32'h1234_5678);
    chk("single_Busy_after", 32'(Busy), 32'd0);
    cyc();
    @(negedge Clk);
    chk("single_pulse_ends", 32'(RegWrite), 32'd0);
    chk("single_hold_reg", 32'(WriteRegister), 32'd5);

    // Sustained contention from reset: alternating drains, one per cycle
    do_reset();
    alog.delete(); dlog.delete();
    set_a(5'd3, 32'hA);
    set_b(5'd4, 32'hB);
    repeat (5) cyc();
    idle();
    repeat (4) cyc();
    chk("contend_count", 32'(alog.size()), 32'd5);
    if (alog.size() == 5) begin
      chk("contend_0", 32'(alog[0]), 32'd3);
      chk("contend_1", 32'(alog[1]), 32'd4);
      chk("contend_2", 32'(alog[2]), 32'd3);
      chk("contend_3", 32'(alog[3]), 32'd4);
      chk("contend_4", 32'(alog[4]), 32'd3);
    end

    // Conflict after A was drained last: round robin picks B, fixed priority picks A
    do_reset();
    alog.delete(); dlog.delete();
    set_a(5'd1, 32'h11);
    cyc(); idle(); repeat (3) cyc();
    set_a(5'd3, 32'hA);
    set_b(5'd4, 32'hB);
    cyc(); idle(); repeat (4) cyc();
    chk("ptr_count", 32'(alog.size()), 32'd3);
    if (alog.size() == 3) begin
`ifdef REGFILE_WB_ARBITER_RR_EN
      chk("ptr_first_conflict", 32'(alog[1]), 32'd4);
      chk("ptr_second_conflict", 32'(alog[2]), 32'd3);
`else
      chk("ptr_first_conflict", 32'(alog[1]), 32'd3);
      chk("ptr_second_conflict", 32'(alog[2]), 32'd4);
`endif
    end

    // Same address, A one edge ahead of B
    do_reset();
    dlog.delete();
    set_a(5'd7, 32'h1);
    cyc();
    idle();
    set_b(5'd7, 32'h2);
    cyc(); idle(); repeat (4) cyc();
    chk("same_seq_count", 32'(dlog.size()), 32'd2);
    if (dlog.size() == 2) begin
      chk("same_seq_first", dlog[0], 32'h1);
      chk("same_seq_second", dlog[1], 32'h2);
    end
    chk("same_seq_rf7", rf_dut[7], 32'h2);
    chk("same_seq_model_rf7", m_rf[7], 32'h2);

    // Same address captured together after A was drained last: ordering beats round robin
    dlog.delete();
    set_a(5'd1, 32'h11);
    cyc(); idle(); repeat (3) cyc();
    set_a(5'd7, 32'h1);
    set_b(5'd7, 32'h2);
    cyc(); idle(); repeat (4) cyc();
    chk("same_tie_count", 32'(dlog.size()), 32'd3);
    if (dlog.size() == 3) begin
      chk("same_tie_first", dlog[1], 32'h1);
      chk("same_tie_second", dlog[2], 32'h2);
    end
    chk("same_tie_rf7", rf_dut[7], 32'h2);

    // 300 writes to register 0: never enabled, counter saturates
    do_reset();
    rw_before = rw_cnt;
    n = 0;
    iter = 0;
    while (n < 300 && iter < 2000) begin
      ValidA = ReadyA;
      if (ReadyA) n++;
      ValidB = ReadyB && (n < 300);
      if (ValidB) n++;
      AddrA = 5'd0; AddrB = 5'd0;
      DataA = $urandom; DataB = $urandom;
      cyc();
      iter++;
    end
    idle();
    repeat (4) cyc();
    @(negedge Clk);
    chk("zero_transfers", 32'(n), 32'd300);
    chk("zero_no_regwrite", 32'(rw_cnt - rw_before), 32'd0);
    chk("zero_DropCount", 32'(DropCount), 32'd255);
    chk("zero_model_drop", 32'(m_drop), 32'd255);

    // Reset while both buffers hold writes
    set_a(5'd9, 32'h99);
    set_b(5'd10, 32'hAA);
    cyc();
    idle();
    Reset = 1'b1;
    rw_before = rw_cnt;
    cyc();
    Reset = 1'b0;
    @(negedge Clk);
    chk_reset_values("midrst");
    repeat (3) cyc();
    chk("midrst_no_pulse", 32'(rw_cnt - rw_before), 32'd0);

    // Randomized traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      int r;
      Reset  = ($urandom_range(0, 199) == 0);
      ValidA = ($urandom_range(0, 3) != 0);
      ValidB = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 7);
      AddrA = (r == 0) ? 5'd0 : (r < 3) ? 5'd7 : 5'($urandom_range(0, 31));
      r = $urandom_range(0, 7);
      AddrB = (r == 0) ? 5'd0 : (r < 3) ? 5'd7 : 5'($urandom_range(0, 31));
      DataA = $urandom;
      DataB = $urandom;
      cyc();
    end
    Reset = 1'b0;
    idle();
    repeat (4) cyc();
    @(negedge Clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
